// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter sampler.
package perf_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, SWEEP, CLEAR} state_t;

    localparam int CTR_CYCLE   = 0;
    localparam int CTR_INSTR   = 1;
    localparam int CTR_CHIT    = 2;
    localparam int CTR_CMISS   = 3;
    localparam int CTR_BTAKEN  = 4;
    localparam int CTR_BNTAKEN = 5;
    localparam int CTR_BMISP   = 6;
    localparam int CTR_STALL   = 7;
    localparam int CTR_IRQ     = 8;

    localparam int DEF_NUM_CTRS = 9;
    localparam int DEF_SEL_W    = 4;
    localparam int DEF_DATA_W   = 32;

    typedef struct packed {
        logic [DEF_SEL_W-1:0]  index;
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/perf_sample_fifo.sv
// Synchronous FIFO for sampled counter entries; DEPTH must be a power of two.
module perf_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 37,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    free
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Storage is not reset, so an empty FIFO presents zeros rather than stale data.
    assign head = (count != '0) ? mem[rd_ptr] : '0;
    assign free = CW'(DEPTH) - count;

endmodule

// File: rtl/perf_sampler.sv
// Periodic freeze-and-sweep sampler for the performance-counter unit.
// Define PERF_SAMPLER_IRQ_EN to generate the sweep-complete irq pulse; otherwise irq is tied low.
module perf_sampler
    import perf_pkg::*;
#(
    parameter int NUM_CTRS   = DEF_NUM_CTRS,
    parameter int SEL_W      = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int PERIOD_W   = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic                auto_clear,
    output logic                ctr_enable,
    output logic [SEL_W-1:0]    ctr_select,
    output logic                ctr_reset,
    input  logic [DATA_W-1:0]   ctr_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [SEL_W-1:0]    out_index,
    output logic                out_last,
    output logic                busy,
    output logic                overflow,
    output logic                irq
);

    localparam int EW = SEL_W + 1 + DATA_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CTRS - 1);

    state_t              state;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] load_val;
    logic                clear_q;
    logic                stop_pend;
    logic                push;
    logic                last_sel;
    logic                room;
    logic [EW-1:0]       push_data;
    logic [EW-1:0]       head;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       fifo_free;

    assign load_val  = (period == '0) ? PERIOD_W'(1) : period;
    assign push      = (state == SWEEP);
    assign last_sel  = (ctr_select == LAST_SEL);
    assign push_data = {ctr_select, last_sel, ctr_value};
    assign room      = (fifo_free >= CW'(NUM_CTRS));

    perf_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (out_valid && out_ready),
        .head      (head),
        .count     (fifo_count),
        .free      (fifo_free)
    );

    assign out_valid = (fifo_count != '0);
    assign {out_index, out_last, out_data} = head;

    // A stop seen mid-sweep is parked in stop_pend so the sweep and its clear always finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            period_q   <= '0;
            clear_q    <= 1'b0;
            stop_pend  <= 1'b0;
            ctr_enable <= 1'b0;
            ctr_select <= '0;
            ctr_reset  <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            ctr_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        period_q   <= load_val;
                        timer      <= load_val;
                        clear_q    <= auto_clear;
                        overflow   <= 1'b0;
                        stop_pend  <= 1'b0;
                        ctr_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (stop) begin
                        state      <= IDLE;
                        ctr_enable <= 1'b0;
                        busy       <= 1'b0;
                    end else if (timer == PERIOD_W'(1)) begin
                        if (room) begin
                            state      <= SWEEP;
                            ctr_enable <= 1'b0;
                            ctr_select <= '0;
                        end else begin
                            overflow <= 1'b1;
                            timer    <= period_q;
                        end
                    end else begin
                        timer <= timer - PERIOD_W'(1);
                    end
                end
                SWEEP: begin
                    if (stop) stop_pend <= 1'b1;
                    if (last_sel) begin
                        ctr_select <= '0;
                        if (clear_q) begin
                            state     <= CLEAR;
                            ctr_reset <= 1'b1;
                        end else if (stop || stop_pend) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            state      <= WAIT;
                            timer      <= period_q;
                            ctr_enable <= 1'b1;
                        end
                    end else begin
                        ctr_select <= ctr_select + SEL_W'(1);
                    end
                end
                CLEAR: begin
                    if (stop || stop_pend) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                    end else begin
                        state      <= WAIT;
                        timer      <= period_q;
                        ctr_enable <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERF_SAMPLER_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= push && last_sel;
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: doc/perf_sampler.md
# perf_sampler

Autonomous sampling controller for the performance-counter unit. Every programmable period it freezes the counters, sweeps the counter-select mux across all counters, and pushes each value into an output FIFO drained by a valid/ready reader (debug port or bus slave). It can optionally clear the counters after each sweep, giving per-interval deltas.

## Interface
Parameters:
- NUM_CTRS, 9: counters swept, indices 0..NUM_CTRS-1.
- SEL_W, 4: counter-select width.
- DATA_W, 32: counter value width.
- FIFO_DEPTH, 16: output FIFO entries, power of two, ≥ NUM_CTRS.
- PERIOD_W, 24: period register width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; latches period/auto_clear, leaves IDLE.
- stop  in  1  pulse; return to IDLE after any in-progress sweep.
- period  in  PERIOD_W  cycles between sweeps; 0 treated as 1.
- auto_clear  in  1  clear counters after each sweep.
- ctr_enable  out  1  counting enable to counter unit.
- ctr_select  out  SEL_W  counter select to counter unit.
- ctr_reset  out  1  synchronous clear to counter unit.
- ctr_value  in  DATA_W  selected counter value (combinational from ctr_select).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  reader accepts head.
- out_data  out  DATA_W  counter value.
- out_index  out  SEL_W  counter index of out_data.
- out_last  out  1  entry is final counter of its sweep.
- busy  out  1  state ≠ IDLE.
- overflow  out  1  sticky: a sweep was dropped; cleared by start or rst.
- irq  out  1  sweep-complete pulse (see Configuration).

## Operation
- States: IDLE, WAIT, SWEEP, CLEAR.
- IDLE: ctr_enable=0, ctr_select=0. On start: load timer = max(period,1), latch auto_clear, clear overflow, go WAIT.
- WAIT: ctr_enable=1, timer decrements each cycle. When timer=1 and no stop: if FIFO free entries ≥ NUM_CTRS go SWEEP, else set overflow, reload timer, stay WAIT. Counters are not sampled on a dropped sweep.
- SWEEP: ctr_enable=0 (values frozen and coherent). Cycle k (k=0..NUM_CTRS-1): ctr_select=k; push {k, ctr_value, last=(k==NUM_CTRS-1)} at cycle end. After the last push go CLEAR if auto_clear, else WAIT with timer reloaded.
- CLEAR: one cycle, ctr_reset=1, ctr_enable=0; then WAIT with timer reloaded.
- stop in WAIT or IDLE → IDLE next cycle. stop in SWEEP/CLEAR is recorded and honoured once the sweep (and any clear) completes. Sweeps are never truncated.
- start while busy is ignored. start and stop in the same cycle: stop wins.
- FIFO pops when out_valid & out_ready. Simultaneous push and pop are allowed. The reader may stall indefinitely; only new sweeps are dropped.
- Sweep cycles (NUM_CTRS, +1 with auto_clear) are not counted by the counter unit. Software accounts for this.

## Timing
- Reset values: state IDLE, ctr_enable=0, ctr_select=0, ctr_reset=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, overflow=0, irq=0, FIFO empty.
- All outputs are registered except out_* (FIFO head, registered storage).
- start at edge n → busy=1 and ctr_enable=1 from n+1. The first sweep begins max(period,1) cycles later.
- Sweep interval with auto_clear=0 is period+NUM_CTRS cycles; with auto_clear=1 it is period+NUM_CTRS+1.
- A pushed entry is visible on out_valid the cycle after its push.
- rst mid-sweep: FIFO flushed, partial sweep discarded, all outputs go to reset values immediately.

## Configuration
- PERF_SAMPLER_IRQ_EN defined: irq pulses high for exactly one cycle, the cycle after the last entry of a sweep is pushed. No pulse occurs on a dropped sweep.
- PERF_SAMPLER_IRQ_EN undefined: irq is tied to 0 and no irq logic is generated. All other behaviour is identical.

## Structure
- Package perf_pkg holds:
  - state enum (IDLE, WAIT, SWEEP, CLEAR);
  - counter index constants CTR_CYCLE=0, CTR_INSTR=1, CTR_CHIT=2, CTR_CMISS=3, CTR_BTAKEN=4, CTR_BNTAKEN=5, CTR_BMISP=6, CTR_STALL=7, CTR_IRQ=8;
  - NUM_CTRS default;
  - FIFO entry struct {index, last, data}.
- One sub-module, perf_sample_fifo: synchronous FIFO with parameterised depth and width. It provides push, pop, head, count and free outputs.

## Test plan
- period=4, auto_clear=0, out_ready=1, counter model counting: first push occurs 4 cycles after start. The sweep yields indices 0..8 with out_last only on index 8, and values match the model frozen at sweep start.
- auto_clear=1: ctr_reset pulses one cycle after the index-8 push. All second-sweep values equal the events in the interval, and the cycle counter reads period.
- out_ready=0, period=2, depth 16: first sweep stored (9 entries). Second sweep is dropped (free=7), overflow=1, and no irq on the drop. Raising out_ready drains 9 entries, and the next sweep succeeds.
- stop asserted at sweep index 3: all 9 entries are still pushed, then IDLE with busy=0. start with period=0 behaves as period=1.
- rst asserted at sweep index 5: out_valid=0 and overflow=0 the next cycle, no further pushes, and state is IDLE.
- With PERF_SAMPLER_IRQ_EN: one 1-cycle irq per completed sweep over 3 sweeps. Without the macro, irq stays 0 throughout.
